core_pc_pred: RTL and testbench

Fetch-stage PC generator with a branch predictor, placed directly upstream of the IF/ID pipeline register.
- Holds the fetch PC and drives the instruction-memory address.
- Predicts the next PC from a direct-mapped BTB plus a 2-bit-counter PHT indexed by PC and global history.
- Forwards the prediction metadata (pred_target, delayed_PHT, delayed_BHR, btb_type, btb_v) alongside each fetched instruction, so EX can later update the predictor and redirect on a mispredict.

---
 rtl/core_bp_pkg.sv | 23 ++
 rtl/core_btb.sv | 60 ++++++
 rtl/core_pc_pred.sv | 105 ++++++++++
 tb/tb_core_pc_pred.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/core_bp_pkg.sv
// Shared definitions for the fetch-stage branch predictor: BTB type codes,
// counter reset value, widths and the 2-bit saturating-counter update.
package core_bp_pkg;

  localparam int XLEN   = 32;
  localparam int TYPE_W = 2;
  localparam int CNT_W  = 2;

  localparam logic [TYPE_W-1:0] BT_COND = 2'b00;
  localparam logic [TYPE_W-1:0] BT_JUMP = 2'b01;
  localparam logic [TYPE_W-1:0] BT_CALL = 2'b10;
  localparam logic [TYPE_W-1:0] BT_RET  = 2'b11;

  // Weak not-taken.
  localparam logic [CNT_W-1:0] PHT_RESET = 2'b01;

  function automatic logic [CNT_W-1:0] sat_update(input logic [CNT_W-1:0] cnt,
                                                  input logic taken);
    if (taken) return (cnt == 2'b11) ? cnt : cnt + 2'b01;
    else       return (cnt == 2'b00) ? cnt : cnt - 2'b01;
  endfunction

endpackage

// File: rtl/core_btb.sv
// Direct-mapped branch target buffer: combinational read, synchronous write,
// asynchronous clear of the valid bits only.
module core_btb
  import core_bp_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   rd_pc,
  output logic              hit,
  output logic [XLEN-1:0]   rd_target,
  output logic [TYPE_W-1:0] rd_type,
  input  logic              we,
  input  logic [XLEN-1:0]   wr_pc,
  input  logic [XLEN-1:0]   wr_target,
  input  logic [TYPE_W-1:0] wr_type
);

  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [N-1:0]      valid_q;
  logic [TAG_W-1:0]  tag_q    [N];
  logic [XLEN-1:0]   target_q [N];
  logic [TYPE_W-1:0] type_q   [N];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             unused_lsbs;

  assign rd_idx      = rd_pc[IDX_W+1:2];
  assign rd_tag      = rd_pc[XLEN-1:IDX_W+2];
  assign wr_idx      = wr_pc[IDX_W+1:2];
  assign wr_tag      = wr_pc[XLEN-1:IDX_W+2];
  assign unused_lsbs = ^{rd_pc[1:0], wr_pc[1:0]};

  // Reads see pre-write contents; a same-cycle write shows up next cycle.
  assign hit       = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_target = target_q[rd_idx];
  assign rd_type   = type_q[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Payload arrays are gated by valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
      type_q[wr_idx]   <= wr_type;
    end
  end

endmodule

// File: rtl/core_pc_pred.sv
// Fetch PC register with BTB + gshare-style PHT next-PC prediction; exports the
// lookup metadata so EX can train the predictor and repair history.
module core_pc_pred
  import core_bp_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BTB_IDX_W = 4,
  parameter int          PHT_PC_W  = 3,
  parameter int          BHR_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_we,
  input  logic              redirect_v,
  input  logic [XLEN-1:0]   redirect_pc,
  input  logic              upd_v,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic [XLEN-1:0]   upd_target,
  input  logic [TYPE_W-1:0] upd_type,
  input  logic [CNT_W-1:0]  upd_PHT,
  input  logic [BHR_W-1:0]  upd_BHR,
  input  logic              upd_mispred,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   pc_plus_4,
  output logic [XLEN-1:0]   pred_target,
  output logic [CNT_W-1:0]  delayed_PHT,
  output logic [BHR_W-1:0]  delayed_BHR,
  output logic [TYPE_W-1:0] btb_type,
  output logic              btb_v
);

  localparam int PHT_IDX_W = PHT_PC_W + BHR_W;
  localparam int PHT_N     = 1 << PHT_IDX_W;

  logic [XLEN-1:0]      pc_q;
  logic [BHR_W-1:0]     bhr_q;
  logic [CNT_W-1:0]     pht_q [PHT_N];

  logic                 hit;
  logic [XLEN-1:0]      btb_target;
  logic [TYPE_W-1:0]    rd_type;
  logic [PHT_IDX_W-1:0] pht_idx, upd_idx;
  logic [CNT_W-1:0]     pht_rd;
  logic                 pred_taken;
  logic                 spec_shift;

  core_btb #(.IDX_W(BTB_IDX_W)) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_pc     (pc_q),
    .hit       (hit),
    .rd_target (btb_target),
    .rd_type   (rd_type),
    .we        (upd_v && upd_taken),
    .wr_pc     (upd_pc),
    .wr_target (upd_target),
    .wr_type   (upd_type)
  );

  assign pht_idx    = {pc_q[PHT_PC_W+1:2], bhr_q};
  assign upd_idx    = {upd_pc[PHT_PC_W+1:2], upd_BHR};
  assign pht_rd     = pht_q[pht_idx];
  // Unconditional types are always taken on a hit; conditionals follow the counter MSB.
  assign pred_taken = hit && ((rd_type != BT_COND) || pht_rd[1]);
  assign spec_shift = pc_we && !redirect_v && hit && (rd_type == BT_COND);

  assign pc          = pc_q;
  assign pc_plus_4   = pc_q + 32'd4;
  assign pred_target = pred_taken ? btb_target : pc_plus_4;
  assign delayed_PHT = pht_rd;
  assign delayed_BHR = bhr_q;
  assign btb_type    = hit ? rd_type : BT_COND;
  assign btb_v       = hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (redirect_v) begin
      pc_q <= redirect_pc;
    end else if (pc_we) begin
      pc_q <= pred_target;
    end
  end

  // A mispredict repair from EX always wins over the speculative fetch-side shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bhr_q <= '0;
    end else if (upd_v && upd_mispred) begin
      bhr_q <= (upd_type == BT_COND) ? {upd_BHR[BHR_W-2:0], upd_taken} : upd_BHR;
    end else if (spec_shift) begin
      bhr_q <= {bhr_q[BHR_W-2:0], pred_taken};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= PHT_RESET;
    end else if (upd_v && (upd_type == BT_COND)) begin
      pht_q[upd_idx] <= sat_update(upd_PHT, upd_taken);
    end
  end

endmodule

// File: tb/tb_core_pc_pred.sv
// Directed bench for core_pc_pred: fetch sequencing, BTB allocation, PHT
// training/saturation, mispredict history repair and asynchronous reset.
module tb_core_pc_pred;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_we;
  logic        redirect_v;
  logic [31:0] redirect_pc;
  logic        upd_v;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [1:0]  upd_type;
  logic [1:0]  upd_PHT;
  logic [2:0]  upd_BHR;
  logic        upd_mispred;
  logic [31:0] pc;
  logic [31:0] pc_plus_4;
  logic [31:0] pred_target;
  logic [1:0]  delayed_PHT;
  logic [2:0]  delayed_BHR;
  logic [1:0]  btb_type;
  logic        btb_v;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  core_pc_pred dut (
    .clk         (clk),
    .rst         (rst),
    .pc_we       (pc_we),
    .redirect_v  (redirect_v),
    .redirect_pc (redirect_pc),
    .upd_v       (upd_v),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .upd_type    (upd_type),
    .upd_PHT     (upd_PHT),
    .upd_BHR     (upd_BHR),
    .upd_mispred (upd_mispred),
    .pc          (pc),
    .pc_plus_4   (pc_plus_4),
    .pred_target (pred_target),
    .delayed_PHT (delayed_PHT),
    .delayed_BHR (delayed_BHR),
    .btb_type    (btb_type),
    .btb_v       (btb_v)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_upd();
    upd_v = 0; upd_pc = '0; upd_taken = 0; upd_target = '0;
    upd_type = 2'b00; upd_PHT = 2'b00; upd_BHR = 3'b000; upd_mispred = 0;
  endtask

  task automatic set_upd(input logic [31:0] p, input logic tk, input logic [31:0] tgt,
                         input logic [1:0] ty, input logic [1:0] cnt, input logic [2:0] bhr,
                         input logic mp);
    upd_v = 1; upd_pc = p; upd_taken = tk; upd_target = tgt;
    upd_type = ty; upd_PHT = cnt; upd_BHR = bhr; upd_mispred = mp;
  endtask

  initial begin
    rst = 1; pc_we = 0; redirect_v = 0; redirect_pc = '0;
    idle_upd();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    // Reset state
    check("rst_pc", pc, 32'h0);
    check("rst_btb_v", {31'b0, btb_v}, 32'h0);
    check("rst_btb_type", {30'b0, btb_type}, 32'h0);
    check("rst_pht", {30'b0, delayed_PHT}, 32'h1);
    check("rst_bhr", {29'b0, delayed_BHR}, 32'h0);
    check("rst_pred_target", pred_target, 32'h4);
    check("rst_pc_plus_4", pc_plus_4, 32'h4);

    // Sequential fetch then stall
    pc_we = 1;
    step(); check("seq_pc1", pc, 32'h4);
    step(); check("seq_pc2", pc, 32'h8);
    step(); check("seq_pc3", pc, 32'hC);
    step(); check("seq_pc4", pc, 32'h10);
    pc_we = 0;
    step(); check("stall_pc1", pc, 32'h10);
    step(); check("stall_pc2", pc, 32'h10);

    // BTB allocation of a jump at 0x20, performed while stalled
    set_upd(32'h20, 1'b1, 32'h100, 2'b01, 2'b01, 3'b000, 1'b0);
    step(); check("alloc_hold_pc", pc, 32'h10);
    idle_upd();
    pc_we = 1;
    repeat (4) step();
    check("jmp_pc", pc, 32'h20);
    check("jmp_btb_v", {31'b0, btb_v}, 32'h1);
    check("jmp_btb_type", {30'b0, btb_type}, 32'h1);
    check("jmp_pred_target", pred_target, 32'h100);
    step();
    check("jmp_next_pc", pc, 32'h100);
    check("jmp_no_bhr_shift", {29'b0, delayed_BHR}, 32'h0);

    // Conditional training at 0x40: 01 -> 10 -> 11
    pc_we = 0;
    set_upd(32'h40, 1'b1, 32'h300, 2'b00, 2'b01, 3'b000, 1'b0);
    step();
    set_upd(32'h40, 1'b1, 32'h300, 2'b00, 2'b10, 3'b000, 1'b0);
    step();
    idle_upd();
    redirect_v = 1; redirect_pc = 32'h40;
    step();
    redirect_v = 0;
    check("cond_pc", pc, 32'h40);
    check("cond_btb_v", {31'b0, btb_v}, 32'h1);
    check("cond_btb_type", {30'b0, btb_type}, 32'h0);
    check("cond_pht", {30'b0, delayed_PHT}, 32'h3);
    check("cond_pred_target", pred_target, 32'h300);
    pc_we = 1;
    step();
    check("cond_next_pc", pc, 32'h300);
    check("cond_bhr_shift", {29'b0, delayed_BHR}, 32'h1);
    check("miss300_btb_v", {31'b0, btb_v}, 32'h0);
    check("miss300_pht", {30'b0, delayed_PHT}, 32'h1);
    check("miss300_pred_target", pred_target, 32'h304);

    // Mispredict redirect while stalled, history repaired to {01,0}
    pc_we = 0;
    redirect_v = 1; redirect_pc = 32'h200;
    set_upd(32'h40, 1'b0, 32'h300, 2'b00, 2'b11, 3'b101, 1'b1);
    step();
    redirect_v = 0;
    idle_upd();
    check("mp_pc", pc, 32'h200);
    check("mp_bhr", {29'b0, delayed_BHR}, 32'h2);
    check("mp_btb_v", {31'b0, btb_v}, 32'h0);
    check("mp_pht", {30'b0, delayed_PHT}, 32'h1);

    // Collision with current lookup entry {000,010}, then saturation both ways
    set_upd(32'h220, 1'b1, 32'h500, 2'b00, 2'b01, 3'b010, 1'b0);
    #1;
    check("coll_old_pht", {30'b0, delayed_PHT}, 32'h1);
    step();
    check("coll_new_pht", {30'b0, delayed_PHT}, 32'h2);
    set_upd(32'h220, 1'b1, 32'h500, 2'b00, 2'b11, 3'b010, 1'b0);
    step();
    check("sat_hi_pht", {30'b0, delayed_PHT}, 32'h3);
    set_upd(32'h220, 1'b0, 32'h500, 2'b00, 2'b00, 3'b010, 1'b0);
    step();
    check("sat_lo_pht", {30'b0, delayed_PHT}, 32'h0);
    check("sat_hold_pc", pc, 32'h200);

    // Non-conditional mispredict restores history verbatim
    set_upd(32'h80, 1'b1, 32'h600, 2'b11, 2'b01, 3'b110, 1'b1);
    step();
    idle_upd();
    check("restore_bhr", {29'b0, delayed_BHR}, 32'h6);

    // pc+4 wraps modulo 2^32
    redirect_v = 1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_v = 0;
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_pc_plus_4", pc_plus_4, 32'h0);

    // Asynchronous reset mid-run with a pending update that must be dropped
    set_upd(32'h40, 1'b1, 32'h700, 2'b00, 2'b01, 3'b000, 1'b0);
    #1;
    rst = 1;
    #1;
    check("arst_pc", pc, 32'h0);
    check("arst_btb_v", {31'b0, btb_v}, 32'h0);
    check("arst_pht", {30'b0, delayed_PHT}, 32'h1);
    check("arst_bhr", {29'b0, delayed_BHR}, 32'h0);
    check("arst_pred_target", pred_target, 32'h4);
    @(posedge clk);
    #1;
    idle_upd();
    rst = 0;
    redirect_v = 1; redirect_pc = 32'h40;
    step();
    redirect_v = 0;
    check("post_rst_pc", pc, 32'h40);
    check("post_rst_btb_v", {31'b0, btb_v}, 32'h0);
    check("post_rst_pht", {30'b0, delayed_PHT}, 32'h1);
    check("post_rst_pred_target", pred_target, 32'h44);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
